// File: rtl/alsu_cmd_sched.sv
// Two-requester command scheduler for a single ALSU: arbitrates packed commands,
// holds them on the ALSU pins for the pipeline latency and returns the captured result.
module alsu_cmd_sched #(
    parameter int          LAT        = 2,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [15:0] NOP_CMD    = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_cmd,
    output logic [15:0] alsu_cmd,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [5:0]  rsp_out,
    output logic [15:0] rsp_leds,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_id;
    logic          last_id;
    logic          gnt1;
    logic          cmd_err;

    // On a tie the round-robin pointer favours whoever was not granted last.
    always_comb begin
        gnt1 = 1'b0;
        if (req0_valid && req1_valid)
            gnt1 = FIXED_PRIO ? 1'b0 : ~last_id;
        else
            gnt1 = req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !gnt1;
        req1_ready = (state == IDLE) && req1_valid && gnt1;
    end

    always_comb begin
        cmd_err = (alsu_cmd[9:7] == 3'b110) || (alsu_cmd[9:7] == 3'b111) ||
                  ((alsu_cmd[3] | alsu_cmd[2]) && (alsu_cmd[9:7] > 3'b001));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_id    <= 1'b0;
            last_id   <= 1'b1;
            alsu_cmd  <= NOP_CMD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_leds  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        alsu_cmd <= req0_cmd;
                        cur_id   <= 1'b0;
                        last_id  <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT;
                    end else if (req1_ready) begin
                        alsu_cmd <= req1_cmd;
                        cur_id   <= 1'b1;
                        last_id  <= 1'b1;
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(LAT - 1))
                        state <= CAPT;
                end
                CAPT: begin
                    rsp_out   <= alsu_out;
                    rsp_leds  <= alsu_leds;
                    rsp_err   <= cmd_err;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    alsu_cmd  <= NOP_CMD;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
